// File: rtl/mmio_uart_tx_if.sv
// Processor data-memory bus as seen by the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic        io_sel;
  logic [31:0] q_io;

  modport master (output address_dmem, data, wren, input io_sel, q_io);
  modport slave  (input address_dmem, data, wren, output io_sel, q_io);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed by stores, 8N1 serialiser.
//
// state | meaning
// IDLE  | line high; pops the FIFO head as soon as one is present
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [11:0] ADDR_TX      = 12'hFFF,
  parameter logic [11:0] ADDR_STATUS  = 12'hFFE,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy,
  output logic           fifo_full,
  output logic           overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push_req, push_ok, drop, clr, pop;
  logic          ovf_nxt, busy_nxt;
  logic          unused_data;

  assign unused_data = ^bus.data[31:8];

  assign bus.io_sel = (bus.address_dmem == ADDR_TX) || (bus.address_dmem == ADDR_STATUS);
  assign push_req   = bus.wren && (bus.address_dmem == ADDR_TX);
  // Fullness is judged on the pre-edge count; a same-cycle pop never makes room.
  assign push_ok    = push_req && (count != DEPTH_C);
  assign drop       = push_req && (count == DEPTH_C);
  assign clr        = bus.wren && (bus.address_dmem == ADDR_STATUS) && bus.data[0];
  assign pop        = (state == IDLE) && (count != '0);
  assign busy       = (state != IDLE);
  assign fifo_full  = (count == DEPTH_C);

  // Post-edge flag values, so the status word reflects the state after the edge.
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)
      count_nxt = count + CW'(1);
    else if (!push_ok && pop)
      count_nxt = count - CW'(1);
    ovf_nxt = overflow;
    if (drop)
      ovf_nxt = 1'b1;
    else if (clr)
      ovf_nxt = 1'b0;
    if (state == IDLE)
      busy_nxt = (count != '0);
    else
      busy_nxt = !((state == STOP) && (baud_cnt == '0));
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (!reset && push_ok)
      mem[wr_ptr] <= bus.data[7:0];
  end

  // FIFO pointers, occupancy, sticky overflow and registered status word.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      bus.q_io  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count    <= count_nxt;
      overflow <= ovf_nxt;
      if (bus.address_dmem == ADDR_STATUS)
        bus.q_io <= {28'b0, ovf_nxt, (count_nxt == '0), (count_nxt == DEPTH_C), busy_nxt};
      else
        bus.q_io <= '0;
    end
  end

  // Transmit FSM; baud timing uses a down-counter reloaded at each bit boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (count != '0) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            tx       <= shift[0];
            baud_cnt <= BAUD_LAST;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LAST;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_cnt == '0)
            state <= IDLE;
          else
            baud_cnt <= baud_cnt - BW'(1);
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a serial-line receiver checks every frame
// against a scoreboard of bytes expected to be transmitted.
module tb_mmio_uart_tx;
  localparam int          CPB  = 4;
  localparam logic [11:0] A_TX = 12'hFFF;
  localparam logic [11:0] A_ST = 12'hFFE;

  logic clock = 1'b0;
  logic reset;
  logic tx, busy, fifo_full, overflow;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB), .ADDR_TX(A_TX), .ADDR_STATUS(A_ST), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [7:0] sb_q [$];
  int         gap_q [$];
  int         frame_starts = 0;
  int         frames_rx    = 0;

  // Line receiver: sample mid-bit on the falling clock edge.
  bit         m_active = 1'b0;
  int         mcyc     = 0;
  int         idle_run = 1000;
  logic [9:0] m_bits   = '0;

  always @(negedge clock) begin
    if (reset) begin
      m_active = 1'b0;
      idle_run = 1000;
    end else begin
      if (!m_active) begin
        if (tx === 1'b0) begin
          m_active = 1'b1;
          mcyc     = 0;
          frame_starts++;
          gap_q.push_back(idle_run);
          idle_run = 0;
        end else begin
          idle_run++;
        end
      end else begin
        mcyc++;
      end
      if (m_active) begin
        if (mcyc % CPB == CPB / 2) m_bits[mcyc / CPB] = tx;
        if (mcyc == 10 * CPB - 1) begin
          m_active = 1'b0;
          frames_rx++;
          check("start_bit", m_bits[0], 1'b0);
          check("stop_bit", m_bits[9], 1'b1);
          if (sb_q.size() == 0) check("sb_nonempty", 32'(sb_q.size()), 1);
          else check("rx_byte", m_bits[8:1], sb_q.pop_front());
        end
      end
    end
  end

  task automatic store(input logic [11:0] addr, input logic [31:0] d);
    bus.address_dmem = addr;
    bus.data         = d;
    bus.wren         = 1'b1;
    @(posedge clock);
    #1;
    bus.wren         = 1'b0;
    bus.address_dmem = 12'h000;
    bus.data         = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic       exp_tx;
    int         base;
    int         t;

    reset            = 1'b1;
    bus.address_dmem = 12'h000;
    bus.data         = '0;
    bus.wren         = 1'b0;

    // 1: reset with random bus activity
    repeat (10) begin
      @(posedge clock);
      #1;
      bus.wren         = 1'($urandom_range(0, 1));
      bus.address_dmem = ($urandom_range(0, 1) != 0) ? A_TX : A_ST;
      bus.data         = $urandom;
    end
    @(posedge clock);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_q_io", bus.q_io, 32'h0);
    bus.wren         = 1'b0;
    bus.address_dmem = 12'h000;
    reset            = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("rst_no_frame", frame_starts, 0);
    check("rst_idle_tx", tx, 1'b1);
    check("rst_idle_busy", busy, 1'b0);

    // 2: single byte 0xA5, exact waveform
    pat = 8'hA5;
    sb_q.push_back(pat);
    store(A_TX, 32'h0000_00A5);
    @(negedge clock);
    check("t2_tx_e0", tx, 1'b1);
    check("t2_busy_e0", busy, 1'b0);
    for (int i = 1; i <= 41; i++) begin
      @(negedge clock);
      if (i <= 4)       exp_tx = 1'b0;
      else if (i <= 36) exp_tx = pat[(i - 5) / 4];
      else              exp_tx = 1'b1;
      check($sformatf("t2_tx_e%0d", i), tx, exp_tx);
      check($sformatf("t2_busy_e%0d", i), busy, 32'(i <= 40));
    end
    check("t2_frames", frames_rx, 1);

    // 3: ten stores, ninth fills, tenth overflows
    gap_q.delete();
    for (int b = 1; b <= 9; b++) sb_q.push_back(8'(b));
    for (int b = 1; b <= 10; b++) begin
      store(A_TX, 32'(b));
      if (b == 8) check("t3_full_e7", fifo_full, 1'b0);
      if (b == 9) begin
        check("t3_full_e8", fifo_full, 1'b1);
        check("t3_ovf_e8", overflow, 1'b0);
      end
      if (b == 10) begin
        check("t3_full_e9", fifo_full, 1'b1);
        check("t3_ovf_e9", overflow, 1'b1);
      end
    end

    // 4: status read, overflow clear, drain
    repeat (35) @(posedge clock);
    #1;
    bus.address_dmem = A_ST;
    #1;
    check("t4_io_sel", bus.io_sel, 1'b1);
    @(posedge clock);
    #1;
    check("t4_status_ovf_busy", bus.q_io, 32'h9);
    bus.wren = 1'b1;
    bus.data = 32'h1;
    @(posedge clock);
    #1;
    bus.wren = 1'b0;
    bus.data = '0;
    check("t4_ovf_cleared", overflow, 1'b0);
    check("t4_status_after_clr", bus.q_io, 32'h1);
    bus.address_dmem = 12'h000;
    t = 0;
    while (frames_rx < 10 && t < 2000) begin
      @(posedge clock);
      t++;
    end
    check("t4_drain", frames_rx, 10);
    repeat (3) @(posedge clock);
    #1;
    bus.address_dmem = A_ST;
    @(posedge clock);
    #1;
    check("t4_status_drained", bus.q_io, 32'h4);
    bus.address_dmem = 12'h000;
    check("t4_sb_empty", sb_q.size(), 0);
    check("t4_gap_count", gap_q.size(), 9);
    for (int i = 1; i < 9 && i < gap_q.size(); i++)
      check($sformatf("t4_gap%0d", i), gap_q[i], 1);

    // 5: reset in the middle of DATA with bytes queued
    for (int b = 0; b < 4; b++) store(A_TX, 32'h30 + 32'(b));
    repeat (12) @(posedge clock);
    #1;
    check("t5_busy_pre", busy, 1'b1);
    base  = frame_starts;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t5_tx", tx, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_full", fifo_full, 1'b0);
    check("t5_q_io", bus.q_io, 32'h0);
    reset = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    check("t5_no_frames", frame_starts, base);
    check("t5_tx_idle", tx, 1'b1);
    check("t5_busy_idle", busy, 1'b0);

    // 6: stores to unrelated addresses
    base             = frame_starts;
    bus.address_dmem = A_TX;
    #1;
    check("t6_io_sel_tx", bus.io_sel, 1'b1);
    bus.address_dmem = 12'h010;
    bus.data         = 32'h55;
    bus.wren         = 1'b1;
    #1;
    check("t6_io_sel_010", bus.io_sel, 1'b0);
    @(posedge clock);
    #1;
    check("t6_q_io_010", bus.q_io, 32'h0);
    bus.address_dmem = 12'hFFD;
    bus.data         = 32'h66;
    #1;
    check("t6_io_sel_ffd", bus.io_sel, 1'b0);
    @(posedge clock);
    #1;
    bus.wren         = 1'b0;
    bus.address_dmem = A_ST;
    @(posedge clock);
    #1;
    check("t6_status", bus.q_io, 32'h4);
    bus.address_dmem = 12'h000;
    repeat (50) @(posedge clock);
    #1;
    check("t6_no_frames", frame_starts, base);
    check("t6_tx", tx, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
